// File: rtl/timestamp_dds_counter.sv
// DDS-rate timestamp counter with load/clear/add/sub command channel and PPS capture (pps_in source when STAMP_PPS_IN_EN).
// Latency: rate change 1 cycle, command result 2 cycles after acceptance, pps_valid 1 cycle after tick (3 after pps_in edge).
// Backpressure: cmd_ready drops for the single APPLY cycle after each accepted command; no other stalls.
module timestamp_dds_counter #(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int LSB_PAD         = 6,
  parameter int FRAC_WIDTH      = 32,
  parameter int PPS_PERIOD      = 100000000,
  parameter int PPS_CNT_WIDTH   = 27
) (
  input  logic                       axi_aclk,
  input  logic                       axi_resetn,
  input  logic [FRAC_WIDTH-1:0]      dds_rate,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [TIMESTAMP_WIDTH-1:0] cmd_value,
  input  logic                       pps_in,
  output logic [TIMESTAMP_WIDTH-1:0] stamp_counter,
  output logic [TIMESTAMP_WIDTH-1:0] time_pps,
  output logic                       pps_valid,
  output logic                       wrap
);

  localparam int CW = TIMESTAMP_WIDTH - LSB_PAD;
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;

  typedef enum logic {ST_IDLE, ST_APPLY} state_t;

  state_t                     state_q, state_d;
  logic [1:0]                 op_q, op_d;
  logic [CW-1:0]              val_q, val_d;
  logic [CW-1:0]              count_q, count_d;
  logic [FRAC_WIDTH-1:0]      rate_q, acc_q, acc_d;
  logic [FRAC_WIDTH:0]        acc_sum;
  logic                       carry;
  logic                       wrap_q, wrap_d;
  logic [TIMESTAMP_WIDTH-1:0] time_pps_q, time_pps_d;
  logic                       pps_valid_q, pps_valid_d;
  logic                       capture;
  logic                       unused_cmd_lsb;

  assign unused_cmd_lsb = ^cmd_value[LSB_PAD-1:0];
  assign acc_sum        = {1'b0, acc_q} + {1'b0, rate_q};
  assign carry          = acc_sum[FRAC_WIDTH];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    val_d   = val_q;
    acc_d   = acc_sum[FRAC_WIDTH-1:0];
    count_d = count_q + CW'(carry);
    wrap_d  = carry && (&count_q);
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d = ST_APPLY;
          op_d    = cmd_op;
          val_d   = cmd_value[TIMESTAMP_WIDTH-1:LSB_PAD];
        end
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        // wrap flags only a pure carry rollover, never a command result
        wrap_d  = 1'b0;
        case (op_q)
          OP_LOAD: begin
            count_d = val_q;
            acc_d   = '0;
          end
          OP_CLEAR: begin
            count_d = '0;
            acc_d   = '0;
          end
          OP_ADD:  count_d = count_q + val_q + CW'(carry);
          default: count_d = count_q - val_q + CW'(carry);
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // capture sees the pre-command stamp, so a coinciding load/clear reports the old time
  always_comb begin
    pps_valid_d = capture;
    time_pps_d  = capture ? stamp_counter : time_pps_q;
  end

`ifdef STAMP_PPS_IN_EN
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], pps_in};
  end

  assign capture = sync_q[1] & ~sync_q[2];

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) sync_q <= '0;
    else             sync_q <= sync_d;
  end
`else
  logic [PPS_CNT_WIDTH-1:0] pps_cnt_q, pps_cnt_d;
  logic                     restart;
  logic                     unused_pps_in;

  assign unused_pps_in = pps_in;
  assign restart       = (state_q == ST_APPLY) && !op_q[1];
  assign capture       = (pps_cnt_q == PPS_CNT_WIDTH'(PPS_PERIOD - 1));

  always_comb begin
    pps_cnt_d = (capture || restart) ? '0 : pps_cnt_q + PPS_CNT_WIDTH'(1);
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) pps_cnt_q <= '0;
    else             pps_cnt_q <= pps_cnt_d;
  end
`endif

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      val_q       <= '0;
      count_q     <= '0;
      rate_q      <= '0;
      acc_q       <= '0;
      wrap_q      <= 1'b0;
      time_pps_q  <= '0;
      pps_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      val_q       <= val_d;
      count_q     <= count_d;
      rate_q      <= dds_rate;
      acc_q       <= acc_d;
      wrap_q      <= wrap_d;
      time_pps_q  <= time_pps_d;
      pps_valid_q <= pps_valid_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign stamp_counter = {count_q, {LSB_PAD{1'b0}}};
  assign time_pps      = time_pps_q;
  assign pps_valid     = pps_valid_q;
  assign wrap          = wrap_q;

endmodule

// File: tb/tb_timestamp_dds_counter.sv
// Directed bench for timestamp_dds_counter with a 10-cycle internal PPS period.
module tb_timestamp_dds_counter;

  logic        axi_aclk = 1'b0;
  logic        axi_resetn;
  logic [31:0] dds_rate;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [63:0] cmd_value;
  logic        pps_in;
  logic [63:0] stamp_counter;
  logic [63:0] time_pps;
  logic        pps_valid;
  logic        wrap;

  int total = 0;
  int bad   = 0;

  always #5 axi_aclk = ~axi_aclk;

  timestamp_dds_counter #(
    .TIMESTAMP_WIDTH(64),
    .LSB_PAD(6),
    .FRAC_WIDTH(32),
    .PPS_PERIOD(10),
    .PPS_CNT_WIDTH(27)
  ) dut (
    .axi_aclk(axi_aclk),
    .axi_resetn(axi_resetn),
    .dds_rate(dds_rate),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_value(cmd_value),
    .pps_in(pps_in),
    .stamp_counter(stamp_counter),
    .time_pps(time_pps),
    .pps_valid(pps_valid),
    .wrap(wrap)
  );

  // Presents one command at a negedge and returns at the negedge after its APPLY edge.
  task automatic do_cmd(input logic [1:0] op, input logic [63:0] val, input logic [31:0] rate_after);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_value = val;
    @(negedge axi_aclk);
    cmd_valid = 1'b0;
    dds_rate  = rate_after;
    @(negedge axi_aclk);
  endtask

  task automatic test_reset;
    axi_resetn = 1'b0;
    repeat (3) @(negedge axi_aclk);
    total++; if (stamp_counter !== 64'h0) begin bad++; $display("FAIL reset_stamp got %h want 0", stamp_counter); end
    total++; if (time_pps !== 64'h0) begin bad++; $display("FAIL reset_time_pps got %h want 0", time_pps); end
    total++; if (pps_valid !== 1'b0) begin bad++; $display("FAIL reset_pps_valid got %b want 0", pps_valid); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got %b want 0", wrap); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_rate;
    logic [63:0] exp_s;
    axi_resetn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge axi_aclk);
      exp_s = 64'((i - 1) / 2) * 64'h40;
      total++; if (stamp_counter !== exp_s) begin bad++; $display("FAIL rate_edge%0d stamp got %h want %h", i, stamp_counter, exp_s); end
    end
  endtask

  task automatic test_load;
    dds_rate = 32'h0;
    repeat (2) @(negedge axi_aclk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_value = 64'h1234_5678_9ABC_DE7F;
    @(negedge axi_aclk);
    cmd_valid = 1'b0;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL load_busy cmd_ready got %b want 0", cmd_ready); end
    @(negedge axi_aclk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL load_done cmd_ready got %b want 1", cmd_ready); end
    total++; if (stamp_counter !== 64'h1234_5678_9ABC_DE40) begin bad++; $display("FAIL load_value stamp got %h want 123456789abcde40", stamp_counter); end
    @(negedge axi_aclk);
    total++; if (stamp_counter !== 64'h1234_5678_9ABC_DE40) begin bad++; $display("FAIL load_hold stamp got %h want 123456789abcde40", stamp_counter); end
  endtask

  task automatic test_addsub;
    do_cmd(2'b00, 64'h1_0015, 32'h0);
    total++; if (stamp_counter !== 64'h1_0000) begin bad++; $display("FAIL addsub_load stamp got %h want 10000", stamp_counter); end
    do_cmd(2'b11, 64'h7F, 32'h0);
    total++; if (stamp_counter !== 64'hFFC0) begin bad++; $display("FAIL addsub_sub stamp got %h want ffc0", stamp_counter); end
    // one cycle lead so the accumulator carries exactly on the APPLY edge
    dds_rate = 32'h8000_0000;
    @(negedge axi_aclk);
    do_cmd(2'b10, 64'h80, 32'h0);
    total++; if (stamp_counter !== 64'h1_0080) begin bad++; $display("FAIL addsub_add_carry stamp got %h want 10080", stamp_counter); end
    @(negedge axi_aclk);
    total++; if (stamp_counter !== 64'h1_0080) begin bad++; $display("FAIL addsub_hold stamp got %h want 10080", stamp_counter); end
  endtask

  task automatic test_wrap;
    do_cmd(2'b00, 64'hFFFF_FFFF_FFFF_FFC0, 32'h0);
    dds_rate = 32'hFFFF_FFFF;
    @(negedge axi_aclk);
    total++; if (stamp_counter !== 64'hFFFF_FFFF_FFFF_FFC0 || wrap !== 1'b0) begin bad++; $display("FAIL wrap_pre1 stamp/wrap got %h/%b want ffffffffffffffc0/0", stamp_counter, wrap); end
    @(negedge axi_aclk);
    total++; if (stamp_counter !== 64'hFFFF_FFFF_FFFF_FFC0 || wrap !== 1'b0) begin bad++; $display("FAIL wrap_pre2 stamp/wrap got %h/%b want ffffffffffffffc0/0", stamp_counter, wrap); end
    @(negedge axi_aclk);
    dds_rate = 32'h0;
    total++; if (stamp_counter !== 64'h0 || wrap !== 1'b1) begin bad++; $display("FAIL wrap_roll stamp/wrap got %h/%b want 0/1", stamp_counter, wrap); end
    @(negedge axi_aclk);
    total++; if (stamp_counter !== 64'h40 || wrap !== 1'b0) begin bad++; $display("FAIL wrap_post stamp/wrap got %h/%b want 40/0", stamp_counter, wrap); end
    do_cmd(2'b00, 64'hFFFF_FFFF_FFFF_FFC0, 32'h0);
    do_cmd(2'b10, 64'h40, 32'h0);
    total++; if (stamp_counter !== 64'h0 || wrap !== 1'b0) begin bad++; $display("FAIL wrap_add_overflow stamp/wrap got %h/%b want 0/0", stamp_counter, wrap); end
  endtask

  task automatic test_pps;
    logic        exp_v;
    logic [63:0] exp_s;
    logic [63:0] exp_t;
    do_cmd(2'b01, 64'h0, 32'h8000_0000);
    total++; if (stamp_counter !== 64'h0) begin bad++; $display("FAIL pps_clear stamp got %h want 0", stamp_counter); end
    for (int k = 1; k <= 21; k++) begin
      @(negedge axi_aclk);
      exp_v = (k == 10) || (k == 20);
      exp_s = 64'(k / 2) * 64'h40;
      exp_t = (k >= 20) ? 64'h240 : 64'h100;
      total++; if (pps_valid !== exp_v) begin bad++; $display("FAIL pps_a%0d pps_valid got %b want %b", k, pps_valid, exp_v); end
      total++; if (stamp_counter !== exp_s) begin bad++; $display("FAIL pps_a%0d stamp got %h want %h", k, stamp_counter, exp_s); end
      if (k >= 10) begin
        total++; if (time_pps !== exp_t) begin bad++; $display("FAIL pps_a%0d time_pps got %h want %h", k, time_pps, exp_t); end
      end
    end
    // mid-period clear: the old phase would have ticked 7 cycles later
    do_cmd(2'b01, 64'h0, 32'h8000_0000);
    for (int k = 1; k <= 8; k++) begin
      @(negedge axi_aclk);
      exp_s = 64'(k / 2) * 64'h40;
      total++; if (pps_valid !== 1'b0) begin bad++; $display("FAIL pps_b%0d pps_valid got %b want 0", k, pps_valid); end
      total++; if (time_pps !== 64'h240) begin bad++; $display("FAIL pps_b%0d time_pps got %h want 240", k, time_pps); end
      total++; if (stamp_counter !== exp_s) begin bad++; $display("FAIL pps_b%0d stamp got %h want %h", k, stamp_counter, exp_s); end
    end
    // load whose APPLY edge coincides with the tick edge
    do_cmd(2'b00, 64'h1000, 32'h0);
    total++; if (pps_valid !== 1'b1) begin bad++; $display("FAIL pps_coincide pps_valid got %b want 1", pps_valid); end
    total++; if (time_pps !== 64'h100) begin bad++; $display("FAIL pps_coincide time_pps got %h want 100", time_pps); end
    total++; if (stamp_counter !== 64'h1000) begin bad++; $display("FAIL pps_coincide stamp got %h want 1000", stamp_counter); end
    for (int k = 1; k <= 10; k++) begin
      @(negedge axi_aclk);
      exp_v = (k == 10);
      exp_t = (k == 10) ? 64'h1000 : 64'h100;
      total++; if (pps_valid !== exp_v) begin bad++; $display("FAIL pps_c%0d pps_valid got %b want %b", k, pps_valid, exp_v); end
      total++; if (time_pps !== exp_t) begin bad++; $display("FAIL pps_c%0d time_pps got %h want %h", k, time_pps, exp_t); end
      total++; if (stamp_counter !== 64'h1000) begin bad++; $display("FAIL pps_c%0d stamp got %h want 1000", k, stamp_counter); end
    end
  endtask

  task automatic test_reset_apply;
    dds_rate  = 32'h0;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_value = 64'hABCD_0000;
    @(negedge axi_aclk);
    cmd_valid = 1'b0;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_apply_busy cmd_ready got %b want 0", cmd_ready); end
    axi_resetn = 1'b0;
    #1;
    total++; if (stamp_counter !== 64'h0) begin bad++; $display("FAIL rst_apply_stamp got %h want 0", stamp_counter); end
    total++; if (time_pps !== 64'h0) begin bad++; $display("FAIL rst_apply_time_pps got %h want 0", time_pps); end
    total++; if (pps_valid !== 1'b0 || wrap !== 1'b0) begin bad++; $display("FAIL rst_apply_pulses pps_valid/wrap got %b/%b want 0/0", pps_valid, wrap); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_apply_ready got %b want 1", cmd_ready); end
    @(negedge axi_aclk);
    axi_resetn = 1'b1;
    repeat (3) @(negedge axi_aclk);
    total++; if (stamp_counter !== 64'h0) begin bad++; $display("FAIL rst_apply_not_loaded stamp got %h want 0", stamp_counter); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_apply_release_ready got %b want 1", cmd_ready); end
  endtask

  initial begin
    axi_resetn = 1'b0;
    dds_rate   = 32'h8000_0000;
    cmd_valid  = 1'b0;
    cmd_op     = 2'b00;
    cmd_value  = 64'h0;
    pps_in     = 1'b0;
    test_reset();
    test_rate();
    test_load();
    test_addsub();
    test_wrap();
    test_pps();
    test_reset_apply();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timestamp_dds_counter.md
TIMESTAMP_DDS_COUNTER -- requirements
Module: timestamp_dds_counter

Interface
REQ-001 SHALL have parameter TIMESTAMP_WIDTH, default 64: width of the exported timestamp.
REQ-002 SHALL have parameter LSB_PAD, default 6: number of constant-zero LSBs; core count width CW = TIMESTAMP_WIDTH-LSB_PAD.
REQ-003 SHALL have parameter FRAC_WIDTH, default 32: width of the DDS phase accumulator and rate word.
REQ-004 SHALL have parameter PPS_PERIOD, default 100000000: clock cycles per internal second tick.
REQ-005 SHALL have parameter PPS_CNT_WIDTH, default 27: width of the internal tick counter.
REQ-006 SHALL have port axi_aclk, in, 1, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port axi_resetn, in, 1, asynchronous active-low reset.
REQ-008 SHALL have port dds_rate, in, FRAC_WIDTH, the phase increment per cycle.
REQ-009 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_op (in, 2: 00 load, 01 clear, 10 add, 11 sub) and cmd_value (in, TIMESTAMP_WIDTH) forming the time-set command channel.
REQ-010 SHALL have port pps_in, in, 1, the external PPS pulse, used only when STAMP_PPS_IN_EN is defined.
REQ-011 SHALL have ports stamp_counter (out, TIMESTAMP_WIDTH) = {count, LSB_PAD zeros}, time_pps (out, TIMESTAMP_WIDTH), pps_valid (out, 1) and wrap (out, 1).

Function
REQ-012 SHALL register dds_rate into rate_q each cycle; the accumulator uses rate_q, so a rate change takes effect 1 cycle later.
REQ-013 SHALL compute acc_next = acc + rate_q modulo 2^FRAC_WIDTH each cycle, with carry set when the sum is >= 2^FRAC_WIDTH.
REQ-014 SHALL increment count by 1 on carry, modulo 2^CW.
REQ-015 SHALL pulse wrap high for 1 cycle when a carry takes count from all-ones to 0; add/sub overflow SHALL NOT assert wrap.
REQ-016 SHALL implement command FSM IDLE and APPLY; cmd_ready = 1 only in IDLE.
REQ-017 SHALL accept a command on cmd_valid & cmd_ready in IDLE, latch cmd_op and cmd_value, and go to APPLY; IDLE SHALL persist while cmd_valid = 0.
REQ-018 SHALL in APPLY, for load, set count <= cmd_value[TIMESTAMP_WIDTH-1:LSB_PAD], acc <= 0 and pps counter <= 0, discarding that cycle's carry.
REQ-019 SHALL in APPLY, for clear, set count, acc and pps counter to 0, discarding that cycle's carry.
REQ-020 SHALL in APPLY, for add/sub, set count <= count ± cmd_value[TIMESTAMP_WIDTH-1:LSB_PAD] + carry modulo 2^CW, with acc advancing normally.
REQ-021 SHALL return from APPLY to IDLE unconditionally after 1 cycle, giving a result visible on stamp_counter 2 cycles after acceptance.
REQ-022 SHALL treat cmd_value[LSB_PAD-1:0] as don't-care.
REQ-023 SHALL keep carry accumulation in the accept cycle unaffected by the command.
REQ-024 SHALL register pps_valid as a 1-cycle pulse and register time_pps as the stamp_counter value of the capture cycle; time_pps SHALL hold until the next capture.
REQ-025 SHALL, when a load/clear APPLY coincides with an internal tick, perform the capture first (old value) and then restart the counter at 0.

Reset
REQ-026 SHALL, on axi_resetn = 0 (asynchronous), set count, acc, rate_q, time_pps, pps counter and synchroniser flops to 0, set pps_valid and wrap to 0, and set FSM to IDLE (cmd_ready = 1).
REQ-027 SHALL abandon a command in APPLY at reset without applying it.

Configuration
REQ-028 SHALL, with STAMP_PPS_IN_EN defined, synchronise pps_in through 2 flops, detect a rising edge, and capture on that edge: pps_valid 3 cycles after pps_in rises; the internal tick counter SHALL be absent.
REQ-029 SHALL, without STAMP_PPS_IN_EN, ignore pps_in; the internal counter counts 0..PPS_PERIOD-1 and captures in the cycle it equals PPS_PERIOD-1, with pps_valid high the next cycle.

Verification
REQ-030 SHALL verify rate: dds_rate = 32'h8000_0000 after reset -> stamp_counter increments by 0x40 every 2nd cycle, and equals 0x40 at the 3rd clock edge after reset release.
REQ-031 SHALL verify load: load 64'h1234_5678_9ABC_DE7F, rate 0 -> cmd_ready low 1 cycle, stamp_counter = 64'h1234_5678_9ABC_DE40 two cycles after acceptance.
REQ-032 SHALL verify wrap: load 64'hFFFF_FFFF_FFFF_FFC0, rate 32'hFFFF_FFFF -> stamp_counter goes to 0 with a single-cycle wrap pulse.
REQ-033 SHALL verify add/sub: value 0x10_000, sub 0x40 with rate 0 -> 0x10_000 then 0xFFC0; add 0x80 with carry in the APPLY cycle -> +0xC0.
REQ-034 SHALL verify internal PPS: PPS_PERIOD = 10, rate 32'h8000_0000 -> pps_valid every 10 cycles; a clear mid-period restarts phase; time_pps steps by 0x140 between ticks.
REQ-035 SHALL verify reset: axi_resetn low during APPLY of a load -> all outputs 0 immediately, load not applied, cmd_ready = 1 after release.
